power_emu_bus_master: RTL
=========================

Name: power_emu_bus_master

Overview:
Host-side command master that drives the power emulator register slave's single-port read/write bus.
- Accepts read/write commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the slave as a one-cycle strobe and captures read data at the slave's fixed 1-cycle registered read latency.
- Returns exactly one response per command.
- Screens out addresses the slave does not service: writes only to addr 0..3, reads only from addr 5..7.

Parameters:
- DATA_W, 32, slave data width
- ADDR_W, 3, slave address width
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
- WR_ADDR_MAX, 3, highest writable slave address
- RD_ADDR_MIN, 5, lowest readable slave address
- CNT_W, 16, width of the saturating transaction/error counters

Ports:
- clk  in  1  clock
- reset_n  in  1  reset_n, synchronous, active-low; clock clk
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clk edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  slave address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  echo of cmd_write
- rsp_addr  out  ADDR_W  echo of cmd_addr
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address illegal for the operation; not issued to slave
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data, valid the cycle after s_read
- txn_cnt  out  CNT_W  saturating count of commands issued to the slave
- err_cnt  out  CNT_W  saturating count of rejected commands

Behaviour:
- Reset, sampled at a clk edge with reset_n=0:
  - All outputs take their reset values: cmd_ready=0, rsp_*=0, s_*=0, txn_cnt=err_cnt=0.
  - FIFO emptied, FSM returns to IDLE.
  - An in-flight transaction is abandoned and its response discarded; s_read/s_write are low from the first post-reset cycle.
- cmd_ready = !fifo_full, registered from FIFO state; it is 0 during reset. Push happens on handshake. Push and pop in the same cycle are allowed.
- All s_* outputs are registered. s_read and s_write are never both high and each is high for exactly 1 cycle per issued command.
- FSM states and transitions:
  - IDLE: if FIFO not empty, pop the head entry.
    - Legal write (addr<=WR_ADDR_MAX) -> ISSUE with s_write=1.
    - Legal read (addr>=RD_ADDR_MIN) -> ISSUE with s_read=1.
    - Illegal -> RESP with rsp_err=1, rsp_rdata=0, no strobe, err_cnt+1.
  - ISSUE: strobe high this cycle; txn_cnt+1. Read -> WAIT; write -> RESP (rsp_rdata=0, rsp_err=0).
  - WAIT: capture s_rdata into rsp_rdata at the edge -> RESP. s_rdata is sampled in no other state.
  - RESP: rsp_valid=1 with all rsp_* fields stable; on rsp_ready -> IDLE. The next pop happens no earlier than the IDLE cycle.
- Latency, counted from the cmd handshake edge into an empty, idle block:
  - Read: strobe visible in cycle +2, rsp_valid in cycle +4.
  - Write: strobe in cycle +2, rsp_valid in cycle +3.
  - Error: rsp_valid in cycle +2.
- Throughput: one command per 4 cycles for reads, 3 for writes, with rsp_ready held at 1.
- Capacity: FIFO_DEPTH queued commands plus 1 in the FSM, so 5 accepted with rsp_ready=0.
- Counters saturate at all-ones and do not wrap.
- Address 4 is illegal for both reads and writes.

Decomposition:
- Package power_emu_pkg holds:
  - FSM state enum {IDLE, ISSUE, WAIT, RESP}
  - cmd_t struct {write, addr, wdata}
  - WR_ADDR_MAX/RD_ADDR_MIN defaults
  - a function addr_legal(write, addr)
- Sub-module power_emu_cmd_fifo: synchronous FIFO of cmd_t with DEPTH, push/pop/full/empty, first-word-fall-through head. Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

Test Plan:
- Write addr 2 data 0xDEADBEEF, rsp_ready=1 -> s_write=1 with s_addr=2 and s_wdata=0xDEADBEEF for exactly 1 cycle (cycle +2); rsp_valid at +3 with rsp_err=0, rsp_rdata=0; txn_cnt=1.
- Read addr 6 with the slave holding 0x66666666 -> s_read for 1 cycle at +2; rsp_valid at +4 with rsp_rdata=0x66666666, rsp_addr=6.
- Write addr 5, then read addr 4 -> no s_write/s_read ever asserted; two responses with rsp_err=1; err_cnt=2, txn_cnt unchanged.
- rsp_ready=0, push 6 reads back-to-back -> exactly 5 accepted; cmd_ready low after the 5th; only 1 s_read pulse; raising rsp_ready drains 5 in-order responses, then cmd_ready returns to 1.
- Read addr 7, pull reset_n low in WAIT for 1 cycle -> next cycle s_*=0, rsp_valid=0, cmd_ready=0, counters 0; no response for that read ever appears.
- Alternate 3 writes (addr 0..2) and 3 reads (addr 5..7) with rsp_ready=1 -> strobes are never simultaneous; responses arrive in command order; spacing is 3 cycles after a write and 4 after a read.

Source files
------------

// File: rtl/power_emu_pkg.sv
// Shared types and helpers for the power emulator bus master.
package power_emu_pkg;

  localparam int CMD_ADDR_W      = 3;
  localparam int CMD_DATA_W      = 32;
  localparam int WR_ADDR_MAX_DEF = 3;
  localparam int RD_ADDR_MIN_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Widths are fixed here; the top-level DATA_W/ADDR_W must stay equal to these.
  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // The slave only services writes at the low end and reads at the high end.
  function automatic logic addr_legal(input logic                  write,
                                      input logic [CMD_ADDR_W-1:0] addr,
                                      input int                    wr_max,
                                      input int                    rd_min);
    if (write) return (int'(addr) <= wr_max);
    else       return (int'(addr) >= rd_min);
  endfunction

endpackage

// File: rtl/power_emu_cmd_fifo.sv
// Command FIFO with a first-word-fall-through head. Pointers carry one extra
// wrap bit so full and empty are distinguishable.
module power_emu_cmd_fifo
  import power_emu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] head,
  output logic             empty,
  output logic             full_next
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CMD_W-1:0] mem_d [DEPTH];
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Pointer arithmetic, status flags and storage update.
  always_comb begin
    full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    push_ok   = push && !full;
    pop_ok    = pop && !empty;
    wr_ptr_d  = wr_ptr_q + {{PW{1'b0}}, push_ok};
    rd_ptr_d  = rd_ptr_q + {{PW{1'b0}}, pop_ok};
    full_next = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
    head      = mem_q[rd_ptr_q[PW-1:0]];
    mem_d     = mem_q;
    if (push_ok) mem_d[wr_ptr_q[PW-1:0]] = push_data;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/power_emu_bus_master.sv
// Host-side master for the power emulator register slave bus.
//
//   state | meaning
//   IDLE  | waiting for a queued command; pops and screens the head
//   ISSUE | strobe on the slave bus this cycle
//   WAIT  | slave read data valid this cycle; captured at the edge
//   RESP  | response presented until rsp_ready
module power_emu_bus_master
  import power_emu_pkg::*;
#(
  parameter int DATA_W      = CMD_DATA_W,
  parameter int ADDR_W      = CMD_ADDR_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_ADDR_MAX = WR_ADDR_MAX_DEF,
  parameter int RD_ADDR_MIN = RD_ADDR_MIN_DEF,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e           state_q, state_d;
  cmd_t             push_cmd;
  cmd_t             head;
  logic [CMD_W-1:0] head_bits;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full_next;
  logic             head_legal;

  logic              cmd_ready_q, cmd_ready_d;
  logic              cur_write_q, cur_write_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Pack the incoming command for the FIFO.
  always_comb begin
    push_cmd       = '0;
    push_cmd.write = cmd_write;
    push_cmd.addr  = cmd_addr;
    push_cmd.wdata = cmd_wdata;
  end

  assign fifo_push  = cmd_valid && cmd_ready_q;
  assign head       = cmd_t'(head_bits);
  assign head_legal = addr_legal(head.write, head.addr, WR_ADDR_MAX, RD_ADDR_MIN);

  power_emu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head_bits),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = head_legal ? ISSUE : RESP;
      ISSUE:   state_d = cur_write_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; strobes are registered on the pop edge so
  // they are visible exactly while the FSM sits in ISSUE.
  always_comb begin
    fifo_pop    = 1'b0;
    cmd_ready_d = !fifo_full_next;
    cur_write_d = cur_write_q;
    cur_addr_d  = cur_addr_q;
    s_read_d    = 1'b0;
    s_write_d   = 1'b0;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cur_write_d = head.write;
          cur_addr_d  = head.addr;
          if (head_legal) begin
            s_read_d  = !head.write;
            s_write_d = head.write;
            s_addr_d  = head.addr;
            s_wdata_d = head.write ? head.wdata : '0;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_write_d = head.write;
            rsp_addr_d  = head.addr;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
          end
        end
      end
      ISSUE: begin
        txn_cnt_d = sat_inc(txn_cnt_q);
        if (cur_write_q) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_addr_d  = cur_addr_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        rsp_addr_d  = cur_addr_q;
        rsp_rdata_d = s_rdata;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_ready_q <= 1'b0;
      cur_write_q <= 1'b0;
      cur_addr_q  <= '0;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      cur_write_q <= cur_write_d;
      cur_addr_q  <= cur_addr_d;
      s_read_q    <= s_read_d;
      s_write_q   <= s_write_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign s_read    = s_read_q;
  assign s_write   = s_write_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign txn_cnt   = txn_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
